// File: rtl/debug_pkg.sv
// Shared definitions for the debug output path: arbiter state encoding,
// header tag and the ASCII command bytes understood by the debug unit.
package debug_pkg;

  // Arbiter state encoding (HDR is only reachable with ARB_HEADER_EN).
  localparam logic [1:0] ARB_IDLE  = 2'd0;
  localparam logic [1:0] ARB_HDR   = 2'd1;
  localparam logic [1:0] ARB_GRANT = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ARB_IDLE,
    ST_HDR   = ARB_HDR,
    ST_GRANT = ARB_GRANT
  } arb_state_e;

  // Upper nibble of the packet header byte; lower nibble carries the grantee.
  localparam logic [3:0] ARB_HDR_TAG = 4'hA;

  // ASCII commands shared with the debug unit.
  localparam logic [7:0] DBG_CMD_PIPE   = 8'h50;  // 'P' pipeline dump
  localparam logic [7:0] DBG_CMD_REGS   = 8'h52;  // 'R' register-file dump
  localparam logic [7:0] DBG_CMD_MEM    = 8'h4D;  // 'M' memory dump
  localparam logic [7:0] DBG_CMD_HALT   = 8'h48;  // 'H' halt core
  localparam logic [7:0] DBG_CMD_RESUME = 8'h47;  // 'G' resume core
  localparam logic [7:0] DBG_CHAR_CR    = 8'h0D;
  localparam logic [7:0] DBG_CHAR_LF    = 8'h0A;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority picker: returns the first set request
// strictly after 'last', wrapping modulo N. Also used by the memory-port
// arbiter, so it carries no state of its own.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] winner,
  output logic          any_req
);

  int   idx;
  logic found;

  // Scan N positions starting one past the previous winner.
  always_comb begin
    // NOTE: every variable written here gets a value before any branch,
    // otherwise a path that skips the assignment infers a latch.
    winner  = last;
    any_req = |req;
    found   = 1'b0;
    idx     = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(last) + off) % N;
      if (!found && req[idx[IW-1:0]]) begin
        winner = idx[IW-1:0];
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing the UART TX FIFO write port
// between NUM_REQ byte-stream requesters. A grant lasts until a byte flagged
// last transfers or the stall watchdog revokes it.
// Optional feature: define ARB_HEADER_EN to prefix every packet with a header
// byte {ARB_HDR_TAG, grantee}; DATA_W must then be 8.
module uart_tx_arbiter
  import debug_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                      clock,
  input  logic                      resetN,
  input  logic [NUM_REQ-1:0]        reqValid,
  input  logic [NUM_REQ*DATA_W-1:0] reqData,
  input  logic [NUM_REQ-1:0]        reqLast,
  output logic [NUM_REQ-1:0]        reqReady,
  input  logic                      fifoFull,
  output logic                      fifoWrite,
  output logic [DATA_W-1:0]         fifoData,
  output logic [ID_W-1:0]           grantId,
  output logic                      busy,
  output logic                      timeoutErr
);

  localparam logic [CNT_W-1:0] STALL_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e       state, state_next;
  logic [ID_W-1:0]  grant_next;
  logic [ID_W-1:0]  last_grant, last_grant_next;
  logic [CNT_W-1:0] stall_cnt, stall_cnt_next;

  logic [ID_W-1:0]   pick_id;
  logic              pick_any;
  logic              lane_valid;
  logic              lane_last;
  logic [DATA_W-1:0] lane_data;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_rr_pick (
    .req     (reqValid),
    .last    (last_grant),
    .winner  (pick_id),
    .any_req (pick_any)
  );

  // Lane of the current grantee.
  always_comb begin
    lane_valid = reqValid[grantId];
    lane_last  = reqLast[grantId];
    lane_data  = reqData[grantId*DATA_W +: DATA_W];
  end

  // State register, grantee, round-robin pointer and stall counter.
  always_ff @(posedge clock or negedge resetN) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!resetN) begin
      state      <= ST_IDLE;
      grantId    <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
      stall_cnt  <= '0;
    end else begin
      state      <= state_next;
      grantId    <= grant_next;
      last_grant <= last_grant_next;
      stall_cnt  <= stall_cnt_next;
    end
  end

  // Next-state logic and all port outputs.
  always_comb begin
    state_next      = state;
    grant_next      = grantId;
    last_grant_next = last_grant;
    stall_cnt_next  = stall_cnt;
    reqReady        = '0;
    fifoWrite       = 1'b0;
    fifoData        = '0;
    timeoutErr      = 1'b0;
    busy            = (state != ST_IDLE);

    case (state)
      ST_IDLE: begin
        stall_cnt_next = '0;
        if (pick_any) begin
          grant_next = pick_id;
`ifdef ARB_HEADER_EN
          state_next = ST_HDR;
`else
          state_next = ST_GRANT;
`endif
        end
      end

`ifdef ARB_HEADER_EN
      ST_HDR: begin
        // Header waits on the FIFO as long as needed; watchdog stays idle.
        stall_cnt_next = '0;
        fifoWrite      = !fifoFull;
        if (!fifoFull) begin
          fifoData   = DATA_W'({ARB_HDR_TAG, 4'(grantId)});
          state_next = ST_GRANT;
        end
      end
`endif

      ST_GRANT: begin
        reqReady[grantId] = !fifoFull;
        fifoWrite         = lane_valid && !fifoFull;
        if (lane_valid && !fifoFull) begin
          fifoData       = lane_data;
          stall_cnt_next = '0;
          if (lane_last) begin
            state_next      = ST_IDLE;
            last_grant_next = grantId;
          end
        end else if (!fifoFull) begin
          // Requester stalled while the FIFO could take data.
          if (stall_cnt == STALL_LIMIT) begin
            timeoutErr      = 1'b1;
            state_next      = ST_IDLE;
            last_grant_next = grantId;
            stall_cnt_next  = '0;
          end else begin
            stall_cnt_next = stall_cnt + CNT_W'(1);
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. Requesters are modelled as byte queues
// that advance on reqValid & reqReady; FIFO writes are captured into a queue
// and compared with hand-built expected streams. A second instance with a
// shorter watchdog shares the stimulus to show backpressure is not a stall.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 2;
  localparam int DATA_W  = 8;
  localparam int ID_W    = 1;
`ifdef ARB_HEADER_EN
  localparam int HC = 1;
`else
  localparam int HC = 0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic                      clock;
  logic                      resetN;
  logic [NUM_REQ-1:0]        reqValid;
  logic [NUM_REQ*DATA_W-1:0] reqData;
  logic [NUM_REQ-1:0]        reqLast;
  logic [NUM_REQ-1:0]        reqReady;
  logic                      fifoFull;
  logic                      fifoWrite;
  logic [DATA_W-1:0]         fifoData;
  logic [ID_W-1:0]           grantId;
  logic                      busy;
  logic                      timeoutErr;

  logic [NUM_REQ-1:0]        t4_reqReady;
  logic                      t4_fifoWrite;
  logic [DATA_W-1:0]         t4_fifoData;
  logic [ID_W-1:0]           t4_grantId;
  logic                      t4_busy;
  logic                      t4_timeoutErr;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT_CYCLES(8)) u_dut (
    .clock      (clock),
    .resetN     (resetN),
    .reqValid   (reqValid),
    .reqData    (reqData),
    .reqLast    (reqLast),
    .reqReady   (reqReady),
    .fifoFull   (fifoFull),
    .fifoWrite  (fifoWrite),
    .fifoData   (fifoData),
    .grantId    (grantId),
    .busy       (busy),
    .timeoutErr (timeoutErr)
  );

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT_CYCLES(4)) u_dut_t4 (
    .clock      (clock),
    .resetN     (resetN),
    .reqValid   (reqValid),
    .reqData    (reqData),
    .reqLast    (reqLast),
    .reqReady   (t4_reqReady),
    .fifoFull   (fifoFull),
    .fifoWrite  (t4_fifoWrite),
    .fifoData   (t4_fifoData),
    .grantId    (t4_grantId),
    .busy       (t4_busy),
    .timeoutErr (t4_timeoutErr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  beat_t              src_q[NUM_REQ][$];
  logic [NUM_REQ-1:0] src_en;
  logic [7:0]         got_q[$];
  logic [7:0]         exp_q[$];
  int                 checks;
  int                 failures;

  logic               s_write, s_busy, s_terr, s_t4_terr;
  logic [7:0]         s_data;
  logic [NUM_REQ-1:0] s_ready;
  logic [ID_W-1:0]    s_gid;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic add_beat(input int i, input logic [7:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    src_q[i].push_back(b);
  endtask

  task automatic exp_hdr(input int id);
`ifdef ARB_HEADER_EN
    exp_q.push_back(8'hA0 | 8'(id));
`endif
  endtask

  task automatic drive_lanes();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src_en[i] && src_q[i].size() > 0) begin
        reqValid[i]                 = 1'b1;
        reqData[i*DATA_W +: DATA_W] = src_q[i][0].data;
        reqLast[i]                  = src_q[i][0].last;
      end else begin
        reqValid[i]                 = 1'b0;
        reqData[i*DATA_W +: DATA_W] = '0;
        reqLast[i]                  = 1'b0;
      end
    end
  endtask

  // One clock cycle: drive lanes, sample at the falling edge, retire accepted
  // beats, then step past the rising edge.
  task automatic tick();
    beat_t b;
    drive_lanes();
    @(negedge clock);
    s_write   = fifoWrite;
    s_data    = fifoData;
    s_ready   = reqReady;
    s_busy    = busy;
    s_terr    = timeoutErr;
    s_t4_terr = t4_timeoutErr;
    s_gid     = grantId;
    if (fifoWrite) got_q.push_back(fifoData);
    for (int i = 0; i < NUM_REQ; i++)
      if (reqValid[i] && reqReady[i]) b = src_q[i].pop_front();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_assert();
    resetN = 1'b0;
    #1;
  endtask

  task automatic clear_src();
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    src_en   = '0;
    fifoFull = 1'b0;
    drive_lanes();
  endtask

  task automatic reset_release();
    @(posedge clock);
    #1;
    resetN = 1'b1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: bench did not finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    checks   = 0;
    failures = 0;
    resetN   = 1'b0;
    src_en   = '0;
    fifoFull = 1'b0;
    reqValid = '0;
    reqData  = '0;
    reqLast  = '0;

    // 1: single 3-byte packet from requester 0 right after reset.
    reset_assert();
    clear_src();
    add_beat(0, 8'h11, 1'b0);
    add_beat(0, 8'h22, 1'b0);
    add_beat(0, 8'h33, 1'b1);
    src_en = 2'b01;
    drive_lanes();
    #1;
    check("rst_ready", reqReady, 0);
    check("rst_write", fifoWrite, 0);
    check("rst_data", fifoData, 0);
    check("rst_busy", busy, 0);
    check("rst_terr", timeoutErr, 0);
    check("rst_gid", grantId, 0);
    reset_release();
    tick();
    check("t1_arb_write", s_write, 0);
    check("t1_arb_busy", s_busy, 0);
    repeat (HC) tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t1_wr%0d", k), s_write, 1);
      check($sformatf("t1_gid%0d", k), s_gid, 0);
    end
    tick();
    check("t1_end_busy", s_busy, 0);
    check("t1_end_write", s_write, 0);
    check("t1_end_gid", s_gid, 0);
    exp_hdr(0);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    check_stream("t1_stream");

    // 2: both requesters always valid, round-robin alternation.
    reset_assert();
    clear_src();
    reset_release();
    add_beat(0, 8'hA0, 1'b0);
    add_beat(0, 8'hA1, 1'b1);
    add_beat(0, 8'hA0, 1'b0);
    add_beat(0, 8'hA1, 1'b1);
    add_beat(1, 8'hB0, 1'b0);
    add_beat(1, 8'hB1, 1'b1);
    src_en = 2'b11;
    for (int k = 0; k < 3 * (3 + HC); k++) begin
      tick();
      check($sformatf("t2_write%0d", k), s_write, (k % (3 + HC)) != 0);
      check($sformatf("t2_busy%0d", k), s_busy, (k % (3 + HC)) != 0);
    end
    exp_hdr(0);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA1);
    exp_hdr(1);
    exp_q.push_back(8'hB0);
    exp_q.push_back(8'hB1);
    exp_hdr(0);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA1);
    check_stream("t2_stream");

    // 3: FIFO backpressure mid-packet.
    reset_assert();
    clear_src();
    reset_release();
    for (int b = 1; b <= 5; b++) add_beat(0, 8'(b), b == 5);
    src_en = 2'b01;
    tick();
    repeat (HC) tick();
    tick();
    check("t3_ready_open", s_ready, 2'b01);
    tick();
    fifoFull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("t3_full_ready%0d", k), s_ready, 0);
      check($sformatf("t3_full_write%0d", k), s_write, 0);
      check($sformatf("t3_full_terr8_%0d", k), s_terr, 0);
      check($sformatf("t3_full_terr4_%0d", k), s_t4_terr, 0);
      check($sformatf("t3_full_busy%0d", k), s_busy, 1);
    end
    fifoFull = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("t3_resume%0d", k), s_write, 1);
    end
    tick();
    check("t3_end_busy", s_busy, 0);
    exp_hdr(0);
    for (int b = 1; b <= 5; b++) exp_q.push_back(8'(b));
    check_stream("t3_stream");

    // 4: watchdog revokes a stalled grant after 8 idle cycles.
    reset_assert();
    clear_src();
    reset_release();
    add_beat(1, 8'h77, 1'b0);
    src_en = 2'b10;
    tick();
    repeat (HC) tick();
    tick();
    check("t4_wr_write", s_write, 1);
    check("t4_wr_data", s_data, 8'h77);
    check("t4_wr_gid", s_gid, 1);
    add_beat(0, 8'h99, 1'b1);
    src_en = 2'b11;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check($sformatf("t4_terr%0d", k), s_terr, k == 8);
      check($sformatf("t4_busy%0d", k), s_busy, 1);
      check($sformatf("t4_ready%0d", k), s_ready, 2'b10);
    end
    tick();
    check("t4_idle_busy", s_busy, 0);
    check("t4_idle_terr", s_terr, 0);
    repeat (HC) tick();
    tick();
    check("t4_next_write", s_write, 1);
    check("t4_next_gid", s_gid, 0);
    check("t4_next_data", s_data, 8'h99);

    // 5: asynchronous reset in the middle of a packet.
    reset_assert();
    clear_src();
    reset_release();
    add_beat(1, 8'hC0, 1'b0);
    add_beat(1, 8'hC1, 1'b0);
    add_beat(1, 8'hC2, 1'b0);
    add_beat(1, 8'hC3, 1'b1);
    src_en = 2'b10;
    tick();
    repeat (HC) tick();
    tick();
    tick();
    check("t5_pre_busy", busy, 1);
    check("t5_pre_gid", grantId, 1);
    reset_assert();
    check("t5_rst_ready", reqReady, 0);
    check("t5_rst_write", fifoWrite, 0);
    check("t5_rst_data", fifoData, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_terr", timeoutErr, 0);
    check("t5_rst_gid", grantId, 0);
    add_beat(0, 8'h42, 1'b1);
    src_en = 2'b11;
    reset_release();
    tick();
    check("t5_arb_busy", s_busy, 0);
    repeat (HC) tick();
    tick();
    check("t5_win_gid", s_gid, 0);
    check("t5_win_write", s_write, 1);
    check("t5_win_data", s_data, 8'h42);

    // 6: single-byte packet from requester 1 (header-prefixed when enabled).
    reset_assert();
    clear_src();
    reset_release();
    add_beat(1, 8'h5C, 1'b1);
    src_en = 2'b10;
    repeat (3 + HC) tick();
    exp_hdr(1);
    exp_q.push_back(8'h5C);
    check_stream("t6_stream");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
